// File: rtl/trace_reader.sv
// Trace source poller: fetches address/data pairs over a two-phase ready/want
// handshake and queues non-empty records in a first-word-fall-through FIFO.
module trace_reader #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        activated,
   input  logic [4:0]  addr,
   input  logic        addr_ready,
   output logic        addr_want,
   input  logic [31:0] data,
   input  logic        data_ready,
   output logic        data_want,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_addr,
   output logic [31:0] out_data,
   output logic [31:0] rec_count,
   output logic [15:0] poll_count,
   output logic        err_timeout,
   input  logic        err_clr
);

   localparam int unsigned AW       = $clog2(FIFO_DEPTH);
   localparam logic [9:0]  TMO_LAST = 10'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AWAIT,
      S_AREQ,
      S_AREL,
      S_DWAIT,
      S_DREQ,
      S_DREL
   } state_t;

   state_t        r_state;
   logic          r_addr_want;
   logic          r_data_want;
   logic          r_activated;
   logic          r_err_timeout;
   logic [4:0]    r_addr;
   logic [31:0]   r_data;
   logic [9:0]    r_tmo_cnt;
   logic [31:0]   r_rec_count;
   logic [15:0]   r_poll_count;

   logic [36:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_tmo_hit;

   assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_push    = (r_state == S_DREL);
   assign w_pop     = !w_empty && out_ready;
   assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

   // Wants default low each cycle and are re-asserted only while entering or
   // holding a request state, so they track S_AREQ/S_DREQ exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_addr_want   <= 1'b0;
         r_data_want   <= 1'b0;
         r_activated   <= 1'b0;
         r_err_timeout <= 1'b0;
         r_addr        <= '0;
         r_data        <= '0;
         r_tmo_cnt     <= '0;
         r_rec_count   <= '0;
         r_poll_count  <= '0;
      end else begin
         r_addr_want <= 1'b0;
         r_data_want <= 1'b0;
         if (err_clr)
            r_err_timeout <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_tmo_cnt <= '0;
               if (enable) begin
                  r_state     <= S_AWAIT;
                  r_activated <= 1'b1;
               end
            end

            S_AWAIT: begin
               if (!enable) begin
                  r_state     <= S_IDLE;
                  r_activated <= 1'b0;
                  r_tmo_cnt   <= '0;
               end else if (addr_ready) begin
                  r_state     <= S_AREQ;
                  r_addr_want <= 1'b1;
                  r_tmo_cnt   <= '0;
               end else if (w_tmo_hit) begin
                  r_state       <= S_IDLE;
                  r_activated   <= 1'b0;
                  r_err_timeout <= 1'b1;
                  r_tmo_cnt     <= '0;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 10'd1;
               end
            end

            S_AREQ: begin
               if (!addr_ready) begin
                  r_addr    <= addr;
                  r_state   <= S_AREL;
                  r_tmo_cnt <= '0;
               end else if (w_tmo_hit) begin
                  r_state       <= S_IDLE;
                  r_activated   <= 1'b0;
                  r_err_timeout <= 1'b1;
                  r_tmo_cnt     <= '0;
               end else begin
                  r_addr_want <= 1'b1;
                  r_tmo_cnt   <= r_tmo_cnt + 10'd1;
               end
            end

            S_AREL: begin
               r_tmo_cnt <= '0;
               if (r_addr == '0) begin
                  if (r_poll_count != 16'hFFFF)
                     r_poll_count <= r_poll_count + 16'd1;
                  r_state <= S_AWAIT;
               end else begin
                  r_state <= S_DWAIT;
               end
            end

            // A full FIFO is consumer backpressure, not a stalled source,
            // so those cycles neither count nor clear the timeout.
            S_DWAIT: begin
               if (data_ready && !w_full) begin
                  r_state     <= S_DREQ;
                  r_data_want <= 1'b1;
                  r_tmo_cnt   <= '0;
               end else if (!w_full) begin
                  if (w_tmo_hit) begin
                     r_state       <= S_IDLE;
                     r_activated   <= 1'b0;
                     r_err_timeout <= 1'b1;
                     r_tmo_cnt     <= '0;
                  end else begin
                     r_tmo_cnt <= r_tmo_cnt + 10'd1;
                  end
               end
            end

            S_DREQ: begin
               if (!data_ready) begin
                  r_data    <= data;
                  r_state   <= S_DREL;
                  r_tmo_cnt <= '0;
               end else if (w_tmo_hit) begin
                  r_state       <= S_IDLE;
                  r_activated   <= 1'b0;
                  r_err_timeout <= 1'b1;
                  r_tmo_cnt     <= '0;
               end else begin
                  r_data_want <= 1'b1;
                  r_tmo_cnt   <= r_tmo_cnt + 10'd1;
               end
            end

            S_DREL: begin
               r_rec_count <= r_rec_count + 32'd1;
               r_state     <= S_AWAIT;
               r_tmo_cnt   <= '0;
            end

            default: begin
               r_state     <= S_IDLE;
               r_activated <= 1'b0;
               r_tmo_cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {r_addr, r_data};
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign activated   = r_activated;
   assign addr_want   = r_addr_want;
   assign data_want   = r_data_want;
   assign out_valid   = !w_empty;
   assign out_addr    = r_mem[r_rd_ptr][36:32];
   assign out_data    = r_mem[r_rd_ptr][31:0];
   assign rec_count   = r_rec_count;
   assign poll_count  = r_poll_count;
   assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_trace_reader.sv
// Bench for trace_reader: a reactive source model feeds records, a scoreboard
// holds what the source handed out and is checked as the consumer pops.
module tb_trace_reader;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        activated;
   logic [4:0]  addr;
   logic        addr_ready;
   logic        addr_want;
   logic [31:0] data;
   logic        data_ready;
   logic        data_want;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic [31:0] rec_count;
   logic [15:0] poll_count;
   logic        err_timeout;
   logic        err_clr;

   trace_reader #(.FIFO_DEPTH(4), .TIMEOUT(1023)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .activated   (activated),
      .addr        (addr),
      .addr_ready  (addr_ready),
      .addr_want   (addr_want),
      .data        (data),
      .data_ready  (data_ready),
      .data_want   (data_want),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_addr    (out_addr),
      .out_data    (out_data),
      .rec_count   (rec_count),
      .poll_count  (poll_count),
      .err_timeout (err_timeout),
      .err_clr     (err_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_cmp = 0;
   int          n_err = 0;
   logic [36:0] src_q [$];
   logic [36:0] sb    [$];
   logic        src_stuck  = 1'b0;
   logic        data_stuck = 1'b0;
   int          n_popped   = 0;
   int          dw_pulses  = 0;
   int          n_both     = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Source and consumer agent, acting 1 time unit after each falling edge.
   initial begin
      logic [36:0] e;
      logic [36:0] cur;
      logic        dw_prev;
      cur        = '0;
      dw_prev    = 1'b0;
      addr       = '0;
      data       = '0;
      addr_ready = 1'b0;
      data_ready = 1'b1;
      forever begin
         @(negedge clk);
         #1;
         if (out_valid && out_ready) begin
            n_popped++;
            if (sb.size() == 0)
               chk("sb_underflow", 64'(sb.size()), 64'd1);
            else begin
               e = sb.pop_front();
               chk("record", {27'b0, out_addr, out_data}, {27'b0, e});
            end
         end
         if (data_want && !dw_prev)
            dw_pulses++;
         dw_prev = data_want;
         if (addr_want && data_want)
            n_both++;

         if (src_stuck)
            addr_ready = 1'b1;
         else if (addr_want) begin
            addr_ready = 1'b0;
            if (src_q.size() != 0) begin
               cur  = src_q.pop_front();
               addr = cur[36:32];
            end
         end else
            addr_ready = (src_q.size() != 0);

         if (data_stuck)
            data_ready = 1'b1;
         else if (data_want) begin
            data_ready = 1'b0;
            data       = cur[31:0];
            sb.push_back(cur);
         end else
            data_ready = 1'b1;
      end
   end

   initial begin
      int n;
      int pops0;
      int dw0;
      int dw_hi;
      reset   = 1'b1;
      enable  = 1'b0;
      out_ready = 1'b1;
      err_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_addr_want", addr_want, 0);
      chk("rst_data_want", data_want, 0);
      chk("rst_activated", activated, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rec_count", rec_count, 0);
      chk("rst_poll_count", poll_count, 0);
      chk("rst_err", err_timeout, 0);
      reset = 1'b0;
      @(negedge clk);

      // Three empty polls
      pops0 = n_popped;
      for (int i = 0; i < 3; i++) src_q.push_back('0);
      enable = 1'b1;
      for (int i = 0; i < 100 && poll_count != 16'd3; i++) @(negedge clk);
      enable = 1'b0;
      chk("poll_count", poll_count, 3);
      repeat (3) @(negedge clk);
      chk("poll_rec_count", rec_count, 0);
      chk("poll_out_valid", out_valid, 0);
      chk("poll_no_pop", 64'(n_popped - pops0), 0);
      chk("poll_idle", activated, 0);

      // Single record with latency from S_AWAIT entry to out_valid
      dw0   = dw_pulses;
      pops0 = n_popped;
      src_q.push_back({5'd5, 32'hDEADBEEF});
      enable = 1'b1;
      for (int i = 0; i < 10 && !activated; i++) @(negedge clk);
      chk("single_activated", activated, 1);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      chk("single_latency", 64'(n), 6);
      for (int i = 0; i < 50 && rec_count != 32'd1; i++) @(negedge clk);
      enable = 1'b0;
      repeat (4) @(negedge clk);
      chk("single_rec_count", rec_count, 1);
      chk("single_dw_pulses", 64'(dw_pulses - dw0), 1);
      chk("single_popped", 64'(n_popped - pops0), 1);
      chk("single_sb_empty", 64'(sb.size()), 0);
      chk("single_out_valid", out_valid, 0);

      // Backpressure: five records, FIFO of four, hold well past TIMEOUT
      out_ready = 1'b0;
      pops0 = n_popped;
      for (int i = 0; i < 5; i++)
         src_q.push_back({5'(i + 1), 32'hA000_0000 + 32'(i * 17)});
      enable = 1'b1;
      for (int i = 0; i < 200 && rec_count != 32'd5; i++) @(negedge clk);
      chk("bp_buffered", rec_count, 5);
      dw0   = dw_pulses;
      dw_hi = 0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         if (data_want) dw_hi++;
      end
      chk("bp_dw_low", 64'(dw_hi), 0);
      chk("bp_no_dw_pulse", 64'(dw_pulses - dw0), 0);
      chk("bp_no_err", err_timeout, 0);
      chk("bp_rec_count", rec_count, 5);
      chk("bp_activated", activated, 1);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_addr_taken", 64'(src_q.size()), 0);
      out_ready = 1'b1;
      for (int i = 0; i < 100 && !(rec_count == 32'd6 && sb.size() == 0 && !out_valid); i++)
         @(negedge clk);
      enable = 1'b0;
      chk("bp_drain_rec", rec_count, 6);
      chk("bp_drain_popped", 64'(n_popped - pops0), 5);
      repeat (3) @(negedge clk);

      // Timeout in S_AREQ, then a second one coinciding with err_clr
      for (int run = 0; run < 2; run++) begin
         src_stuck = 1'b1;
         enable    = 1'b1;
         for (int i = 0; i < 20 && !addr_want; i++) @(negedge clk);
         chk("tmo_want_seen", addr_want, 1);
         n = 0;
         while (addr_want && n < 1100) begin
            err_clr = (run == 1 && n == 1022);
            @(negedge clk);
            n++;
         end
         err_clr = 1'b0;
         enable  = 1'b0;
         chk("tmo_cycles", 64'(n), 1023);
         chk("tmo_err_set", err_timeout, 1);
         chk("tmo_want_low", addr_want, 0);
         chk("tmo_idle", activated, 0);
         src_stuck = 1'b0;
         repeat (3) @(negedge clk);
         chk("tmo_sticky", err_timeout, 1);
      end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("tmo_cleared", err_timeout, 0);

      // Reset while in S_DREQ with one record buffered
      out_ready = 1'b0;
      src_q.push_back({5'd9, 32'h0900_0009});
      src_q.push_back({5'd17, 32'h1100_0011});
      enable = 1'b1;
      for (int i = 0; i < 50 && rec_count != 32'd7; i++) @(negedge clk);
      chk("rdq_first_push", rec_count, 7);
      data_stuck = 1'b1;
      for (int i = 0; i < 30 && !data_want; i++) @(negedge clk);
      chk("rdq_in_dreq", data_want, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      data_stuck = 1'b0;
      chk("rdq_addr_want", addr_want, 0);
      chk("rdq_data_want", data_want, 0);
      chk("rdq_out_valid", out_valid, 0);
      chk("rdq_rec_count", rec_count, 0);
      chk("rdq_poll_count", poll_count, 0);
      chk("rdq_activated", activated, 0);
      out_ready = 1'b1;
      src_q.push_back('0);
      for (int i = 0; i < 30 && poll_count != 16'd1; i++) @(negedge clk);
      chk("rdq_restart_poll", poll_count, 1);
      enable = 1'b0;
      repeat (3) @(negedge clk);

      // Enable dropped during S_AREQ: record still completes, then idle
      pops0 = n_popped;
      src_q.push_back({5'd7, 32'h7777_0007});
      enable = 1'b1;
      for (int i = 0; i < 20 && !addr_want; i++) @(negedge clk);
      chk("edrop_areq", addr_want, 1);
      enable = 1'b0;
      for (int i = 0; i < 30 && rec_count != 32'd1; i++) @(negedge clk);
      chk("edrop_rec_count", rec_count, 1);
      repeat (2) @(negedge clk);
      chk("edrop_idle", activated, 0);
      repeat (3) @(negedge clk);
      chk("edrop_popped", 64'(n_popped - pops0), 1);
      chk("edrop_sb_empty", 64'(sb.size()), 0);
      chk("wants_exclusive", 64'(n_both), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
